// File: rtl/alu_pipe_if.sv
// alu_pipe_if -- request/response bundle for alu_pipe.
//   slave  : the ALU side (consumes requests, produces results and flags)
//   master : the requester/consumer side (testbench or issuing stage)
// Request : in_valid/in_ready handshake with op, mul, cond, set_flags,
//           operands rn/op2, shifter carry and destination tag rd.
// Response: out_valid/out_ready handshake with result, rd, write enable,
//           executed (condition passed); flags is the live NZCV register.
interface alu_pipe_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic             in_mul;
  logic [3:0]       in_cond;
  logic             in_set_flags;
  logic [WIDTH-1:0] in_rn;
  logic [WIDTH-1:0] in_op2;
  logic             in_shifter_carry;
  logic [3:0]       in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_rd;
  logic             out_write;
  logic             out_executed;
  logic [3:0]       flags;

  modport slave (
    input  in_valid, in_op, in_mul, in_cond, in_set_flags, in_rn, in_op2,
           in_shifter_carry, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_write, out_executed, flags
  );

  modport master (
    output in_valid, in_op, in_mul, in_cond, in_set_flags, in_rn, in_op2,
           in_shifter_carry, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_write, out_executed, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe -- ARM-style data-processing ALU with conditional execution,
// a registered NZCV flag register and an iterative shift-add multiplier.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : alu_pipe_if.slave (request in, result out, flags)
// Single-cycle ops produce a result one cycle after acceptance. An executed
// multiply occupies the block for WIDTH cycles (state MUL), during which no
// new request is accepted and no result is presented.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;

  typedef enum logic {IDLE, MUL} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       out_rd_q, out_rd_d;
  logic             out_write_q, out_write_d;
  logic             out_exec_q, out_exec_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       mul_rd_q, mul_rd_d;
  logic             mul_s_q, mul_s_d;

  logic in_ready, accept, cond_pass;
  logic fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags_q;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !reset;
  assign accept   = bus.in_valid && in_ready;

  // Condition check against the flags as they stand in the accept cycle.
  always_comb begin
    cond_pass = 1'b1;
    case (bus.in_cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      default: cond_pass = 1'b1;  // AL and 1111
    endcase
  end

  // Single-cycle datapath. All arithmetic is a + b + cin on WIDTH+1 bits;
  // subtracts invert b and inject carry so C comes out as NOT borrow.
  logic [WIDTH-1:0] a, b, alu_res;
  logic             cin, arith, alu_c, alu_v, alu_wr;
  logic [WIDTH:0]   sum;

  always_comb begin
    a      = bus.in_rn;
    b      = bus.in_op2;
    cin    = 1'b0;
    arith  = 1'b0;
    alu_wr = 1'b1;
    case (bus.in_op)
      OP_SUB, OP_CMP: begin b = ~bus.in_op2; cin = 1'b1; arith = 1'b1; end
      OP_SBC:         begin b = ~bus.in_op2; cin = fc;   arith = 1'b1; end
      OP_RSB:         begin a = bus.in_op2; b = ~bus.in_rn; cin = 1'b1; arith = 1'b1; end
      OP_RSC:         begin a = bus.in_op2; b = ~bus.in_rn; cin = fc;   arith = 1'b1; end
      OP_ADD, OP_CMN: arith = 1'b1;
      OP_ADC:         begin cin = fc; arith = 1'b1; end
      default: ;
    endcase
    if (bus.in_op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN}) alu_wr = 1'b0;
  end

  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    case (bus.in_op)
      OP_AND, OP_TST: alu_res = bus.in_rn & bus.in_op2;
      OP_EOR, OP_TEQ: alu_res = bus.in_rn ^ bus.in_op2;
      OP_ORR:         alu_res = bus.in_rn | bus.in_op2;
      OP_MOV:         alu_res = bus.in_op2;
      OP_BIC:         alu_res = bus.in_rn & ~bus.in_op2;
      OP_MVN:         alu_res = ~bus.in_op2;
      default:        alu_res = sum[WIDTH-1:0];
    endcase
    // Logical ops take C from the shifter and leave V alone.
    alu_c = arith ? sum[WIDTH] : bus.in_shifter_carry;
    alu_v = arith ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])) : fv;
  end

  // Multiplier: one shift-add step per cycle, LSB of multiplier first.
  logic [WIDTH-1:0] acc_next;
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_write_d  = out_write_q;
    out_exec_d   = out_exec_q;
    flags_d      = flags_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    mul_rd_d     = mul_rd_q;
    mul_s_d      = mul_s_q;

    // Retire; a load below in the same cycle overrides this.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_mul && cond_pass) begin
            state_d  = MUL;
            mcand_d  = bus.in_rn;
            mplier_d = bus.in_op2;
            acc_d    = '0;
            cnt_d    = '0;
            mul_rd_d = bus.in_rd;
            mul_s_d  = bus.in_set_flags;
          end else begin
            // Executed single-cycle op, or any op whose condition failed.
            out_valid_d  = 1'b1;
            out_rd_d     = bus.in_rd;
            out_exec_d   = cond_pass;
            out_write_d  = cond_pass && alu_wr;
            out_result_d = bus.in_mul ? '0 : alu_res;
            if (cond_pass && bus.in_set_flags)
              flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
          end
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          out_valid_d  = 1'b1;
          out_result_d = acc_next;
          out_rd_d     = mul_rd_q;
          out_write_d  = 1'b1;
          out_exec_d   = 1'b1;
          if (mul_s_q) flags_d[3:2] = {acc_next[WIDTH-1], (acc_next == '0)};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_write_q  <= 1'b0;
      out_exec_q   <= 1'b0;
      flags_q      <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mul_rd_q     <= '0;
      mul_s_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_write_q  <= out_write_d;
      out_exec_q   <= out_exec_d;
      flags_q      <= flags_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      mul_rd_q     <= mul_rd_d;
      mul_s_q      <= mul_s_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_write    = out_write_q;
  assign bus.out_executed = out_exec_q;
  assign bus.flags        = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- directed vectors for alu_pipe (WIDTH=32) with hand-computed
// expectations. Inputs change and outputs are sampled on the falling edge.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  alu_pipe_if #(.WIDTH(32)) bus ();
  alu_pipe #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one request at a falling edge, confirm it is accepted at the next
  // rising edge, return at the following falling edge with in_valid low.
  task automatic issue(input logic [3:0] op, input logic mul, input logic [3:0] cond,
                       input logic s, input logic [31:0] rn, input logic [31:0] op2,
                       input logic sc, input logic [3:0] rd);
    bus.in_op = op; bus.in_mul = mul; bus.in_cond = cond; bus.in_set_flags = s;
    bus.in_rn = rn; bus.in_op2 = op2; bus.in_shifter_carry = sc; bus.in_rd = rd;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_at_offer", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic ok;
    bus.in_valid = 0; bus.in_op = 0; bus.in_mul = 0; bus.in_cond = 4'hE;
    bus.in_set_flags = 0; bus.in_rn = 0; bus.in_op2 = 0; bus.in_shifter_carry = 0;
    bus.in_rd = 0; bus.out_ready = 1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_write", bus.out_write, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // ADD AL S: 0xFFFFFFFF + 1 -> 0, Z C
    issue(4'd4, 0, 4'hE, 1, 32'hFFFF_FFFF, 32'd1, 0, 4'd3);
    chk("add_valid", bus.out_valid, 1);
    chk("add_result", bus.out_result, 0);
    chk("add_write", bus.out_write, 1);
    chk("add_exec", bus.out_executed, 1);
    chk("add_rd", bus.out_rd, 3);
    chk("add_flags", bus.flags, 4'b0110);

    // CMP 5,5 then ADD NE (fails)
    issue(4'd10, 0, 4'hE, 1, 32'd5, 32'd5, 0, 4'd1);
    chk("cmp_write", bus.out_write, 0);
    chk("cmp_result", bus.out_result, 0);
    chk("cmp_flags", bus.flags, 4'b0110);
    issue(4'd4, 0, 4'h1, 1, 32'd1, 32'd2, 0, 4'd2);
    chk("addne_valid", bus.out_valid, 1);
    chk("addne_exec", bus.out_executed, 0);
    chk("addne_write", bus.out_write, 0);
    chk("addne_flags", bus.flags, 4'b0110);

    // SUB 0x80000000 - 1 -> overflow
    issue(4'd2, 0, 4'hE, 1, 32'h8000_0000, 32'd1, 0, 4'd4);
    chk("sub_result", bus.out_result, 32'h7FFF_FFFF);
    chk("sub_flags", bus.flags, 4'b0011);
    // MOV S with shifter carry 0: Z, C from shifter, V kept
    issue(4'd13, 0, 4'hE, 1, 32'd0, 32'd0, 0, 4'd4);
    chk("mov_flags", bus.flags, 4'b0101);
    // RSB 0 - 1 -> borrow
    issue(4'd3, 0, 4'hE, 1, 32'd1, 32'd0, 0, 4'd4);
    chk("rsb_result", bus.out_result, 32'hFFFF_FFFF);
    chk("rsb_flags", bus.flags, 4'b1000);
    // ADC with C=0
    issue(4'd5, 0, 4'hE, 1, 32'd2, 32'd3, 0, 4'd4);
    chk("adc_result", bus.out_result, 5);
    chk("adc_flags", bus.flags, 4'b0000);
    // MVN 0 with shifter carry 1
    issue(4'd15, 0, 4'hE, 1, 32'd0, 32'd0, 1, 4'd4);
    chk("mvn_result", bus.out_result, 32'hFFFF_FFFF);
    chk("mvn_flags", bus.flags, 4'b1010);
    // BIC without S
    issue(4'd14, 0, 4'hE, 0, 32'hFF, 32'h0F, 0, 4'd6);
    chk("bic_result", bus.out_result, 32'hF0);
    chk("bic_flags", bus.flags, 4'b1010);
    // TST: no writeback
    issue(4'd8, 0, 4'hE, 1, 32'hF0, 32'h0F, 0, 4'd6);
    chk("tst_write", bus.out_write, 0);
    chk("tst_flags", bus.flags, 4'b0100);
    // SBC with C=0: 10 - 3 - 1
    issue(4'd6, 0, 4'hE, 1, 32'd10, 32'd3, 0, 4'd6);
    chk("sbc_result", bus.out_result, 6);
    chk("sbc_flags", bus.flags, 4'b0010);
    // MOV HI (C=1, Z=0 -> passes)
    issue(4'd13, 0, 4'h8, 0, 32'd0, 32'h55, 0, 4'd6);
    chk("movhi_exec", bus.out_executed, 1);
    chk("movhi_result", bus.out_result, 32'h55);
    issue(4'd2, 0, 4'hE, 1, 32'h8000_0000, 32'd1, 0, 4'd4);
    chk("sub2_flags", bus.flags, 4'b0011);

    // Multiply 7*6: 32 busy cycles, result at cycle 32
    issue(4'd0, 1, 4'hE, 1, 32'd7, 32'd6, 0, 4'd5);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("mul_busy_32", ok, 1);
    @(negedge clk);
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_result", bus.out_result, 42);
    chk("mul_rd", bus.out_rd, 5);
    chk("mul_write", bus.out_write, 1);
    chk("mul_flags", bus.flags, 4'b0011);

    // Backpressure: hold 5 cycles, then retire and accept on the same edge
    bus.out_ready = 0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd42 ||
          bus.out_rd !== 4'd5 || bus.out_write !== 1'b1) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    bus.out_ready = 1;
    issue(4'd4, 0, 4'hE, 0, 32'd1, 32'd2, 0, 4'd7);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_result", bus.out_result, 3);
    chk("bp_rd", bus.out_rd, 7);

    // Multiply EQ with Z=0: fails, no MUL state
    issue(4'd0, 1, 4'h0, 1, 32'd7, 32'd6, 0, 4'd8);
    chk("mulfail_valid", bus.out_valid, 1);
    chk("mulfail_exec", bus.out_executed, 0);
    chk("mulfail_write", bus.out_write, 0);
    chk("mulfail_in_ready", bus.in_ready, 1);
    chk("mulfail_flags", bus.flags, 4'b0011);

    // Reset in the middle of a multiply
    issue(4'd0, 1, 4'hE, 1, 32'd7, 32'd6, 0, 4'd9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_flags", bus.flags, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst_release_ready", bus.in_ready, 1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("midrst_no_result", ok, 1);

    // ADD signed overflow after reset
    issue(4'd4, 0, 4'hE, 1, 32'h7FFF_FFFF, 32'd1, 0, 4'd1);
    chk("addv_result", bus.out_result, 32'h8000_0000);
    chk("addv_flags", bus.flags, 4'b1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
